// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latched request, wait-counter width.
package dmem_pkg;
  localparam int WAIT_W    = 4;
  localparam int DMEM_XLEN = 32;
  localparam int DMEM_NB   = DMEM_XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic                 we;
    logic [DMEM_XLEN-1:0] addr;
    logic [DMEM_XLEN-1:0] wdata;
    logic [DMEM_NB-1:0]   be;
  } req_t;
endpackage

// File: rtl/dmem_array.sv
// Byte-strobed single-port word RAM; read and write share one edge, rdata registered (1 cycle).
// No backpressure: an enabled access always completes on the edge it is presented.
module dmem_array #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [XLEN/8-1:0]              be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                rdata
);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] merged;

  // Post-write view of the addressed word, so a store returns what it left behind.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= we ? merged : mem[idx];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: one request at a time, resp_valid WAIT_CYCLES+1 cycles after accept.
// Holds the pipeline via mem_stall until the response cycle; XLEN must match the package request width.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic [XLEN-1:0]   rdata,
  output logic              resp_valid,
  output logic              mem_err,
  output logic              mem_stall
);
  localparam int OFS  = $clog2(XLEN / 8);
  localparam int IDXW = $clog2(DEPTH_WORDS);

  dmem_state_t     state;
  req_t            req;
  req_t            acc;
  logic [WAIT_W-1:0] cnt;
  logic            commit;
  logic            oor;
  logic            have_rd;
  logic [XLEN-1:0] arr_rdata;

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    acc = req;
    if (state == IDLE) begin
      acc.we    = req_we;
      acc.addr  = req_addr;
      acc.wdata = req_wdata;
      acc.be    = req_be;
    end
  end

  assign oor    = (acc.addr >> OFS) >= XLEN'(DEPTH_WORDS);
  assign commit = (state == IDLE && req_valid && WAIT_CYCLES == 0) ||
                  (state == WAIT && cnt == '0);

  dmem_array #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (commit && !oor),
    .we    (acc.we),
    .be    (acc.be),
    .idx   (acc.addr[OFS +: IDXW]),
    .wdata (acc.wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      mem_err    <= 1'b0;
      have_rd    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_err    <= 1'b0;
      if (commit) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        mem_err    <= oor;
        have_rd    <= !oor;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            req <= acc;
            if (WAIT_CYCLES != 0) begin
              cnt   <= WAIT_W'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT:    if (cnt != '0) cnt <= cnt - 1'b1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read register is not resettable; gate it so reset and error responses read as zero.
  assign rdata     = have_rd ? arr_rdata : '0;
  assign mem_stall = (state == IDLE && req_valid) || state == WAIT;
endmodule
